delay_sequencer: RTL and testbench

//  Upstream controller for the 4-bit down-counter (counter). Accepts delay requests
//  (4-bit count + tag) on a valid/ready port and queues them in a small FIFO.

---
 rtl/delay_sequencer_if.sv | 30 +++
 rtl/delay_sequencer.sv | 144 ++++++++++++++
 tb/tb_delay_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_sequencer_if.sv
// delay_sequencer_if: request, done and counter-control bundle around one delay_sequencer.
// Latency: none, wires only.
// Backpressure: req_ready carries the FIFO backpressure; done and counter paths have none.
interface delay_sequencer_if #(
  parameter int TAG_W = 2
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_delay;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       cnt_in;
  logic             cnt_latch;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic             busy;

  // Environment side: issues requests and models the counter.
  modport master (
    output req_valid, req_delay, req_tag, cnt_zero,
    input  req_ready, cnt_in, cnt_latch, cnt_dec, done_valid, done_tag, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_delay, req_tag, cnt_zero,
    output req_ready, cnt_in, cnt_latch, cnt_dec, done_valid, done_tag, busy
  );
endinterface

// File: rtl/delay_sequencer.sv
// delay_sequencer: queues delay jobs and runs each one on an external 4-bit down-counter.
// Latency: done pulse 5 + N*PRESCALE cycles after the accepting edge on an idle, empty unit.
// Backpressure: req_ready drops while the FIFO is full or reset is high; done has none.
module delay_sequencer #(
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 1,
  parameter int TAG_W    = 2
) (
  input  logic             clock,
  input  logic             reset,
  delay_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] L_PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    COUNT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_mem_delay [DEPTH];
  logic [TAG_W-1:0] r_mem_tag   [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [PW-1:0]    r_presc;
  logic [TAG_W-1:0] r_job_tag;
  logic [TAG_W-1:0] r_done_tag;

  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_tick;
  logic [3:0]       w_cnt_in;
  logic             w_cnt_latch;
  logic             w_cnt_dec;
  logic             w_done_valid;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_ready = !w_full && !reset;
  // A full FIFO refuses a push even when LOAD frees a slot in the same cycle.
  assign w_push  = bus.req_valid && w_ready;
  // LOAD is only entered with a non-empty FIFO, so the pop is always legal.
  assign w_pop   = (r_state == LOAD);
  assign w_tick  = (r_presc == L_PS_LAST);

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_delay[r_wptr] <= bus.req_delay;
      r_mem_tag[r_wptr]   <= bus.req_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register plus the per-job registers: prescaler, active tag, reported tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_job_tag  <= '0;
      r_done_tag <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == SETTLE) begin
        r_presc <= '0;
      end else if (r_state == COUNT) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      if (w_pop) r_job_tag <= r_mem_tag[r_rptr];
      // done_tag is copied only when DONE is entered so it holds between jobs.
      if (r_state == COUNT && bus.cnt_zero) r_done_tag <= r_job_tag;
    end
  end

  // Next state and Moore counter/done controls; cnt_dec also respects cnt_zero.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_in     = 4'd0;
    w_cnt_latch  = 1'b0;
    w_cnt_dec    = 1'b0;
    w_done_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_cnt_latch = 1'b1;
        w_cnt_in    = r_mem_delay[r_rptr];
        w_state_nxt = SETTLE;
      end
      SETTLE: begin
        w_state_nxt = COUNT;
      end
      COUNT: begin
        if (bus.cnt_zero) w_state_nxt = DONE;
        else              w_cnt_dec   = w_tick;
      end
      DONE: begin
        w_done_valid = 1'b1;
        w_state_nxt  = w_empty ? IDLE : LOAD;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = w_ready;
  assign bus.cnt_in     = w_cnt_in;
  assign bus.cnt_latch  = w_cnt_latch;
  assign bus.cnt_dec    = w_cnt_dec;
  assign bus.done_valid = w_done_valid;
  assign bus.done_tag   = r_done_tag;
  assign bus.busy       = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_delay_sequencer.sv
// tb_delay_sequencer: directed and random checks of delay_sequencer against a job-timing model.
// Latency: n/a (bench).
// Backpressure: requests are held until req_ready; done is collected every cycle.
module tb_delay_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  // Cycle index: cycle t runs from posedge t to posedge t+1.
  always @(posedge clock) cyc <= cyc + 1;

  delay_sequencer_if #(.TAG_W(TAG_W)) ia ();
  delay_sequencer_if #(.TAG_W(TAG_W)) ib ();

  delay_sequencer #(.DEPTH(DEPTH), .PRESCALE(1), .TAG_W(TAG_W)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ia)
  );

  delay_sequencer #(.DEPTH(DEPTH), .PRESCALE(4), .TAG_W(TAG_W)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ib)
  );

  // Behavioural 4-bit down-counters sitting behind each sequencer.
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  always @(posedge clock) begin
    if (reset)             cnt_a <= 4'd0;
    else if (ia.cnt_latch) cnt_a <= ia.cnt_in;
    else if (ia.cnt_dec)   cnt_a <= cnt_a - 4'd1;
  end
  always @(posedge clock) begin
    if (reset)             cnt_b <= 4'd0;
    else if (ib.cnt_latch) cnt_b <= ib.cnt_in;
    else if (ib.cnt_dec)   cnt_b <= cnt_b - 4'd1;
  end
  assign ia.cnt_zero = (cnt_a == 4'd0);
  assign ib.cnt_zero = (cnt_b == 4'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model for dut_a (PRESCALE=1): each accepted job gets a LOAD cycle
  // L = max(accept+2, previous done+1) and a done cycle L+3+N; everything else follows.
  typedef struct {
    int               a;
    int               l;
    int               d;
    int               n;
    logic [TAG_W-1:0] tag;
  } job_t;

  job_t jobs[$];
  int   last_done = -100;
  logic [TAG_W-1:0] done_q[$];

  // Collect every done pulse of dut_a in order.
  always @(negedge clock) begin
    if (ia.done_valid) done_q.push_back(ia.done_tag);
  end

  // Compare dut_a against the model every cycle, then record this cycle's accept/reset.
  always @(negedge clock) begin : model_a
    int               t;
    int               occ;
    logic             e_busy, e_latch, e_done, e_dec, e_ready;
    logic [3:0]       e_in;
    logic [TAG_W-1:0] e_tag;
    job_t             j;
    t = cyc;
    while (jobs.size() > 0 && jobs[0].d < t) void'(jobs.pop_front());
    occ = 0; e_busy = 0; e_latch = 0; e_done = 0; e_dec = 0; e_in = 4'd0; e_tag = '0;
    foreach (jobs[i]) begin
      if (jobs[i].a < t && jobs[i].l >= t) occ++;
      if (jobs[i].a < t && jobs[i].d >= t) e_busy = 1'b1;
      if (jobs[i].l == t) begin
        e_latch = 1'b1;
        e_in    = 4'(jobs[i].n);
      end
      if (jobs[i].d == t) begin
        e_done = 1'b1;
        e_tag  = jobs[i].tag;
      end
      if (t >= jobs[i].l + 2 && t <= jobs[i].l + 1 + jobs[i].n) e_dec = 1'b1;
    end
    e_ready = !reset && (occ < DEPTH);
    check("a_req_ready", 32'(ia.req_ready), 32'(e_ready));
    check("a_busy", 32'(ia.busy), 32'(e_busy));
    check("a_cnt_latch", 32'(ia.cnt_latch), 32'(e_latch));
    check("a_cnt_in", 32'(ia.cnt_in), 32'(e_in));
    check("a_cnt_dec", 32'(ia.cnt_dec), 32'(e_dec));
    check("a_no_underflow", 32'(ia.cnt_dec & ia.cnt_zero), 32'd0);
    check("a_done_valid", 32'(ia.done_valid), 32'(e_done));
    if (e_done) check("a_done_tag", 32'(ia.done_tag), 32'(e_tag));
    if (!reset && ia.req_valid && e_ready) begin
      j.a   = t;
      j.n   = int'(ia.req_delay);
      j.tag = ia.req_tag;
      j.l   = (t + 2 > last_done + 1) ? t + 2 : last_done + 1;
      j.d   = j.l + 3 + j.n;
      last_done = j.d;
      jobs.push_back(j);
    end
    if (reset) begin
      jobs.delete();
      last_done = -100;
    end
  end

  // Offer one request to dut_a until accepted; call just after a posedge.
  task automatic push_a(input logic [3:0] n, input logic [TAG_W-1:0] tg, output int waited);
    waited = 0;
    ia.req_valid = 1'b1;
    ia.req_delay = n;
    ia.req_tag   = tg;
    forever begin
      @(negedge clock);
      if (ia.req_ready) break;
      waited++;
      if (waited > 400) begin
        check("push_a_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clock); #1;
    ia.req_valid = 1'b0;
  endtask

  // Single job on idle dut_a, handshake in cycle 0; per-cycle activity masks.
  task automatic run_a(input logic [3:0] n, input logic [TAG_W-1:0] tg, input int ncyc,
                       output logic [31:0] m_dec, output logic [31:0] m_latch,
                       output logic [31:0] m_done, output logic [31:0] m_busy,
                       output logic [3:0] lat_in, output logic [TAG_W-1:0] dn_tag);
    m_dec = '0; m_latch = '0; m_done = '0; m_busy = '0; lat_in = '0; dn_tag = '0;
    ia.req_valid = 1'b1;
    ia.req_delay = n;
    ia.req_tag   = tg;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clock);
      if (k == 0) check("run_a_accept", 32'(ia.req_ready), 32'd1);
      m_dec[k]   = ia.cnt_dec;
      m_latch[k] = ia.cnt_latch;
      m_done[k]  = ia.done_valid;
      m_busy[k]  = ia.busy;
      if (ia.cnt_latch)  lat_in = ia.cnt_in;
      if (ia.done_valid) dn_tag = ia.done_tag;
      @(posedge clock); #1;
      ia.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (ia.busy) begin
      n++;
      if (n > 600) begin
        check(tag, 32'(ia.busy), 32'd0);
        break;
      end
      @(negedge clock);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0]      m_dec, m_latch, m_done, m_busy;
    logic [3:0]       lat_in;
    logic [TAG_W-1:0] dn_tag;
    int               w;
    logic             b_under;
    logic [TAG_W-1:0] exp_tags[6];

    ia.req_valid = 1'b0; ia.req_delay = 4'd0; ia.req_tag = '0;
    ib.req_valid = 1'b0; ib.req_delay = 4'd0; ib.req_tag = '0;

    // Reset state, observed while reset is still high.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 32'(ia.req_ready), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done_valid", 32'(ia.done_valid), 32'd0);
    check("rst_done_tag", 32'(ia.done_tag), 32'd0);
    check("rst_cnt_latch", 32'(ia.cnt_latch), 32'd0);
    check("rst_cnt_in", 32'(ia.cnt_in), 32'd0);
    check("rst_b_busy", 32'(ib.busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_ready", 32'(ia.req_ready), 32'd1);
    @(posedge clock); #1;

    // Single N=3 job, tag 2.
    run_a(4'd3, 2'd2, 12, m_dec, m_latch, m_done, m_busy, lat_in, dn_tag);
    check("t1_latch_cycle", m_latch, 32'h4);
    check("t1_cnt_in", 32'(lat_in), 32'd3);
    check("t1_dec_cycles", m_dec, 32'h70);
    check("t1_done_cycle", m_done, 32'h100);
    check("t1_done_tag", 32'(dn_tag), 32'd2);

    // N=0: no decrements, done at cycle 5, busy cycles 1..5.
    run_a(4'd0, 2'd1, 9, m_dec, m_latch, m_done, m_busy, lat_in, dn_tag);
    check("t2_dec_cycles", m_dec, 32'h0);
    check("t2_done_cycle", m_done, 32'h20);
    check("t2_busy_cycles", m_busy, 32'h3E);
    check("t2_done_tag", 32'(dn_tag), 32'd1);

    // FIFO fill: a long job is loaded first so the following five really fill the FIFO.
    done_q.delete();
    push_a(4'd15, 2'd3, w);
    repeat (3) @(posedge clock);
    #1;
    push_a(4'd1, 2'd0, w);
    push_a(4'd1, 2'd1, w);
    push_a(4'd1, 2'd2, w);
    push_a(4'd1, 2'd3, w);
    check("t3_fourth_no_stall", 32'(w), 32'd0);
    push_a(4'd1, 2'd0, w);
    check("t3_fifth_stalled", 32'(w > 0), 32'd1);
    wait_idle_a("t3_drain_timeout");
    exp_tags[0] = 2'd3; exp_tags[1] = 2'd0; exp_tags[2] = 2'd1;
    exp_tags[3] = 2'd2; exp_tags[4] = 2'd3; exp_tags[5] = 2'd0;
    check("t3_done_count", 32'(done_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < done_q.size()) check("t3_done_order", 32'(done_q[i]), 32'(exp_tags[i]));
    end

    // PRESCALE=4, N=2 on the second instance.
    m_dec = '0; m_latch = '0; m_done = '0; b_under = 1'b0; dn_tag = '0;
    ib.req_valid = 1'b1; ib.req_delay = 4'd2; ib.req_tag = 2'd3;
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      m_dec[k]   = ib.cnt_dec;
      m_latch[k] = ib.cnt_latch;
      m_done[k]  = ib.done_valid;
      if (ib.cnt_dec && ib.cnt_zero) b_under = 1'b1;
      if (ib.done_valid) dn_tag = ib.done_tag;
      @(posedge clock); #1;
      ib.req_valid = 1'b0;
    end
    check("t4_latch_cycle", m_latch, 32'h4);
    check("t4_dec_cycles", m_dec, 32'h880);
    check("t4_done_cycle", m_done, 32'h2000);
    check("t4_done_tag", 32'(dn_tag), 32'd3);
    check("t4_no_underflow", 32'(b_under), 32'd0);

    // Reset in the middle of an N=9 count with two jobs queued.
    push_a(4'd9, 2'd1, w);
    push_a(4'd2, 2'd2, w);
    push_a(4'd3, 2'd3, w);
    repeat (3) @(posedge clock);
    #1;
    done_q.delete();
    @(negedge clock);
    check("t5_counting", 32'(ia.busy && !ia.cnt_zero), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t5_busy", 32'(ia.busy), 32'd0);
    check("t5_req_ready", 32'(ia.req_ready), 32'd1);
    check("t5_done_valid", 32'(ia.done_valid), 32'd0);
    check("t5_done_tag", 32'(ia.done_tag), 32'd0);
    @(posedge clock); #1;
    run_a(4'd1, 2'd0, 10, m_dec, m_latch, m_done, m_busy, lat_in, dn_tag);
    check("t5_new_done_cycle", m_done, 32'h40);
    check("t5_done_count", 32'(done_q.size()), 32'd1);

    // Random traffic, occasional resets; the model checks every cycle.
    for (int i = 0; i < 900; i++) begin
      ia.req_valid = ($urandom_range(0, 3) != 0);
      ia.req_delay = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      ia.req_tag   = TAG_W'($urandom);
      reset        = ($urandom_range(0, 249) == 0);
      @(posedge clock); #1;
    end
    ia.req_valid = 1'b0;
    reset = 1'b0;
    wait_idle_a("t6_drain_timeout");
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
